// File: rtl/apb_timeout_slice_if.sv
// APB bus bundle used on both sides of apb_timeout_slice.
// master drives the request, slave returns pready/prdata/pslverr.
interface apb_timeout_slice_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_timeout_slice.sv
// Registered APB slice with downstream hang protection (abort + PSLVERR upstream).
// Optional APB_SLICE_STATS_EN adds txn_count / timeout_count outputs.
module apb_timeout_slice #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hdeadbeef
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_timeout_slice_if.slave  upstream,
  apb_timeout_slice_if.master downstream
`ifdef APB_SLICE_STATS_EN
  ,
  output logic [31:0]         txn_count,
  output logic [15:0]         timeout_count
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        abandoned;

  logic accept;
  logic dn_done;
  logic dn_abort;
  logic up_gone;
  logic drop_resp;

  always_comb begin
    accept    = (state == S_IDLE) && upstream.psel && upstream.penable && !upstream.pready;
    dn_done   = (state == S_ACCESS) && downstream.pready;
    // pready on the limit cycle takes priority over the abort
    dn_abort  = (state == S_ACCESS) && !downstream.pready && (wait_cnt == WAIT_LIMIT);
    up_gone   = ((state == S_SETUP) || (state == S_ACCESS)) && !upstream.psel;
    drop_resp = abandoned || up_gone;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state              <= S_IDLE;
      wait_cnt           <= '0;
      abandoned          <= 1'b0;
      downstream.psel    <= 1'b0;
      downstream.penable <= 1'b0;
      downstream.pwrite  <= 1'b0;
      downstream.paddr   <= '0;
      downstream.pwdata  <= '0;
      downstream.pstrb   <= '0;
      downstream.pprot   <= '0;
      upstream.pready    <= 1'b0;
      upstream.prdata    <= '0;
      upstream.pslverr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          upstream.pready  <= 1'b0;
          upstream.prdata  <= '0;
          upstream.pslverr <= 1'b0;
          if (accept) begin
            downstream.paddr  <= upstream.paddr;
            downstream.pwrite <= upstream.pwrite;
            downstream.pwdata <= upstream.pwdata;
            downstream.pstrb  <= upstream.pstrb;
            downstream.pprot  <= upstream.pprot;
            downstream.psel   <= 1'b1;
            wait_cnt          <= '0;
            abandoned         <= 1'b0;
            state             <= S_SETUP;
          end
        end

        S_SETUP: begin
          downstream.penable <= 1'b1;
          abandoned          <= drop_resp;
          state              <= S_ACCESS;
        end

        S_ACCESS: begin
          abandoned <= drop_resp;
          if (dn_done || dn_abort) begin
            downstream.psel    <= 1'b0;
            downstream.penable <= 1'b0;
            upstream.pready    <= !drop_resp;
            state              <= S_RESP;
            if (drop_resp) begin
              upstream.prdata  <= '0;
              upstream.pslverr <= 1'b0;
            end else if (dn_done) begin
              upstream.prdata  <= downstream.pwrite ? '0 : downstream.prdata;
              upstream.pslverr <= downstream.pslverr;
            end else begin
              upstream.prdata  <= downstream.pwrite ? '0 : TIMEOUT_DATA;
              upstream.pslverr <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_RESP: begin
          upstream.pready  <= 1'b0;
          upstream.prdata  <= '0;
          upstream.pslverr <= 1'b0;
          state            <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef APB_SLICE_STATS_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      txn_count     <= '0;
      timeout_count <= '0;
    end else begin
      if (state == S_RESP) begin
        txn_count <= txn_count + 32'd1;
      end
      if (dn_abort && (timeout_count != 16'hffff)) begin
        timeout_count <= timeout_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_timeout_slice.sv
// Directed + random bench for apb_timeout_slice (TIMEOUT_CYCLES=8).
// Stats checks are compiled in only with APB_SLICE_STATS_EN.
module tb_apb_timeout_slice;

  logic pclk = 1'b0;
  logic preset_n = 1'b1;
  always #5 pclk = ~pclk;

  apb_timeout_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_if ();
  apb_timeout_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dn_if ();

`ifdef APB_SLICE_STATS_EN
  logic [31:0] txn_count;
  logic [15:0] timeout_count;
`endif

  apb_timeout_slice #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (32'hdeadbeef)
  ) dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .upstream     (up_if),
    .downstream   (dn_if)
`ifdef APB_SLICE_STATS_EN
    ,
    .txn_count    (txn_count),
    .timeout_count(timeout_count)
`endif
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Completer model on the downstream side
  logic [31:0] dev_mem [logic [31:0]];
  int  dn_wait = 0;
  bit  dn_stuck = 0;
  bit  dn_err = 0;
  int  acc_cnt = 0;
  int  acc_total = 0;
  int  setup_cyc = -1;
  bit  stable_bad = 0;
  logic [31:0] seen_wdata;
  logic [3:0]  seen_strb;

  function automatic logic [31:0] dev_default(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  initial begin
    dn_if.pready  = 1'b0;
    dn_if.prdata  = '0;
    dn_if.pslverr = 1'b0;
    forever begin
      @(posedge pclk); #1;
      dn_if.pready  = 1'b0;
      dn_if.prdata  = 32'hffff_ffff;
      dn_if.pslverr = 1'b0;
      if (dn_if.psel === 1'b1 && dn_if.penable === 1'b0) begin
        setup_cyc = cyc;
        acc_cnt   = 0;
      end else if (dn_if.psel === 1'b1 && dn_if.penable === 1'b1) begin
        if (acc_cnt == 0) begin
          seen_wdata = dn_if.pwdata;
          seen_strb  = dn_if.pstrb;
        end else if (dn_if.pwdata !== seen_wdata || dn_if.pstrb !== seen_strb) begin
          stable_bad = 1;
        end
        acc_total++;
        if (!dn_stuck && acc_cnt == dn_wait) begin
          dn_if.pready  = 1'b1;
          dn_if.pslverr = dn_err;
          if (dn_if.pwrite) begin
            dev_mem[dn_if.paddr] = dn_if.pwdata;
            dn_if.prdata = 32'hcafe_f00d;
          end else begin
            dn_if.prdata = dev_mem.exists(dn_if.paddr) ? dev_mem[dn_if.paddr] : dev_default(dn_if.paddr);
          end
        end
        acc_cnt++;
      end
    end
  end

  int pready_pulses = 0;
  initial begin
    forever begin
      @(posedge pclk); #1;
      if (up_if.pready === 1'b1) pready_pulses++;
    end
  end

  int n_xfer = 0;
  int last_n = 0;
  int last_lat = 0;

  task automatic up_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic slverr);
    @(posedge pclk); #1;
    up_if.psel    = 1'b1;
    up_if.penable = 1'b0;
    up_if.paddr   = addr;
    up_if.pwrite  = wr;
    up_if.pwdata  = wdata;
    up_if.pstrb   = 4'hf;
    up_if.pprot   = 3'b000;
    @(posedge pclk); #1;
    up_if.penable = 1'b1;
    last_n   = cyc;
    last_lat = 0;
    n_xfer++;
    while (up_if.pready !== 1'b1 && last_lat < 60) begin
      @(posedge pclk); #1;
      last_lat++;
    end
    if (up_if.pready !== 1'b1) chk("pready_wait_expired", 32'd0, 32'd1);
    rdata  = up_if.prdata;
    slverr = up_if.pslverr;
  endtask

  task automatic up_idle();
    @(posedge pclk); #1;
    up_if.psel    = 1'b0;
    up_if.penable = 1'b0;
  endtask

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd;
  logic        err;
  logic [31:0] addr;
  logic [31:0] wd;
  bit          wr;
  int          acc0;
  int          pulses0;

  initial begin
    up_if.psel = 1'b0; up_if.penable = 1'b0; up_if.pwrite = 1'b0;
    up_if.paddr = '0; up_if.pwdata = '0; up_if.pstrb = '0; up_if.pprot = '0;
    dev_mem[32'h404] = 32'h0000_00a5;
    ref_mem[32'h404] = 32'h0000_00a5;

    // Reset state, checked before any clock edge
    #2 preset_n = 1'b0;
    #1;
    chk("rst_dn_psel",    32'(dn_if.psel),    32'd0);
    chk("rst_dn_penable", 32'(dn_if.penable), 32'd0);
    chk("rst_dn_paddr",   dn_if.paddr,        32'd0);
    chk("rst_up_pready",  32'(up_if.pready),  32'd0);
    chk("rst_up_prdata",  up_if.prdata,       32'd0);
    chk("rst_up_pslverr", 32'(up_if.pslverr), 32'd0);
`ifdef APB_SLICE_STATS_EN
    chk("rst_txn_count", txn_count, 32'd0);
    chk("rst_timeout_count", 32'(timeout_count), 32'd0);
`endif
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;

    // Zero-wait read
    dn_wait = 0;
    up_xfer(32'h404, 1'b0, 32'h0, rd, err);
    chk("zw_setup_cycle", 32'(setup_cyc), 32'(last_n + 1));
    chk("zw_latency", 32'(last_lat), 32'd3);
    chk("zw_rdata", rd, 32'h0000_00a5);
    chk("zw_slverr", 32'(err), 32'd0);

    // Write with 4 downstream wait states
    dn_wait = 4;
    stable_bad = 0;
    up_xfer(32'h400, 1'b1, 32'h55, rd, err);
    ref_mem[32'h400] = 32'h55;
    chk("w4_latency", 32'(last_lat), 32'd7);
    chk("w4_slverr", 32'(err), 32'd0);
    chk("w4_rdata_zero", rd, 32'd0);
    chk("w4_dev_wdata", dev_mem[32'h400], 32'h55);
    chk("w4_pstrb", 32'(seen_strb), 32'hf);
    chk("w4_stable", 32'(stable_bad), 32'd0);

    // Stuck completer: abort after 8 ACCESS cycles
    dn_stuck = 1;
    acc0 = acc_total;
    up_xfer(32'h408, 1'b0, 32'h0, rd, err);
    chk("to_access_cycles", 32'(acc_total - acc0), 32'd8);
    chk("to_latency", 32'(last_lat), 32'd10);
    chk("to_dn_psel_low", 32'(dn_if.psel), 32'd0);
    chk("to_slverr", 32'(err), 32'd1);
    chk("to_rdata", rd, 32'hdeadbeef);
`ifdef APB_SLICE_STATS_EN
    chk("to_timeout_count", 32'(timeout_count), 32'd1);
`endif
    dn_stuck = 0;

    // pready on the 8th ACCESS cycle beats the timeout
    dn_wait = 7;
    up_xfer(32'h40c, 1'b0, 32'h0, rd, err);
    chk("edge_latency", 32'(last_lat), 32'd10);
    chk("edge_slverr", 32'(err), 32'd0);
    chk("edge_rdata", rd, dev_default(32'h40c));
`ifdef APB_SLICE_STATS_EN
    chk("edge_timeout_count", 32'(timeout_count), 32'd1);
`endif

    // Completer error on a write passes through, prdata stays 0
    dn_wait = 0;
    dn_err = 1;
    up_xfer(32'h600, 1'b1, 32'h1234, rd, err);
    chk("err_slverr", 32'(err), 32'd1);
    chk("err_rdata", rd, 32'd0);
    dn_err = 0;
    up_idle();
    chk("idle_prdata_zero", up_if.prdata, 32'd0);

    // Upstream drops psel mid-transfer: downstream finishes, no pready upstream
    dn_wait = 3;
    pulses0 = pready_pulses;
    @(posedge pclk); #1;
    up_if.psel = 1'b1; up_if.penable = 1'b0; up_if.paddr = 32'h500;
    up_if.pwrite = 1'b1; up_if.pwdata = 32'h77; up_if.pstrb = 4'hf;
    @(posedge pclk); #1;
    up_if.penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1 up_if.psel = 1'b0; up_if.penable = 1'b0;
    repeat (10) @(posedge pclk);
    #1;
    chk("abandon_no_pready", 32'(pready_pulses), 32'(pulses0));
    chk("abandon_dn_done", dev_mem.exists(32'h500) ? dev_mem[32'h500] : 32'hx, 32'h77);
    chk("abandon_dn_idle", 32'(dn_if.psel), 32'd0);
    ref_mem[32'h500] = 32'h77;

    // Async reset during ACCESS
    dn_stuck = 1;
    @(posedge pclk); #1;
    up_if.psel = 1'b1; up_if.penable = 1'b0; up_if.paddr = 32'h410;
    up_if.pwrite = 1'b0; up_if.pwdata = 32'h0;
    @(posedge pclk); #1;
    up_if.penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk("mr_in_access", 32'(dn_if.penable), 32'd1);
    #2 preset_n = 1'b0;
    #1;
    chk("mr_dn_psel",    32'(dn_if.psel),    32'd0);
    chk("mr_dn_penable", 32'(dn_if.penable), 32'd0);
    chk("mr_dn_paddr",   dn_if.paddr,        32'd0);
    chk("mr_up_pready",  32'(up_if.pready),  32'd0);
    chk("mr_up_prdata",  up_if.prdata,       32'd0);
    up_if.psel = 1'b0; up_if.penable = 1'b0;
    dn_stuck = 0;
    @(posedge pclk); #1 preset_n = 1'b1;
    dn_wait = 1;
    up_xfer(32'h404, 1'b0, 32'h0, rd, err);
    chk("mr_after_latency", 32'(last_lat), 32'd4);
    chk("mr_after_rdata", rd, 32'h0000_00a5);

    // 100 back-to-back random transfers
    for (int unsigned i = 0; i < 100; i++) begin
      addr = 32'h400 + (32'($urandom_range(0, 15)) << 2);
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      dn_wait = int'($urandom_range(0, 3));
      up_xfer(addr, wr, wd, rd, err);
      chk("rnd_latency", 32'(last_lat), 32'(3 + dn_wait));
      chk("rnd_slverr", 32'(err), 32'd0);
      if (wr) begin
        ref_mem[addr] = wd;
        chk("rnd_wr_rdata", rd, 32'd0);
      end else begin
        chk("rnd_rdata", rd, ref_mem.exists(addr) ? ref_mem[addr] : dev_default(addr));
      end
    end
    up_idle();
    repeat (2) @(posedge pclk);
    #1;
    chk("pready_pulses", 32'(pready_pulses), 32'(n_xfer));
`ifdef APB_SLICE_STATS_EN
    chk("rnd_txn_count", txn_count, 32'd101);
    chk("rnd_timeout_count", 32'(timeout_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
